dp_run_ctrl: RTL and testbench

Execution controller for the single-cycle datapath. It generates a one-cycle clock-enable (DpEn) so the datapath runs on the board clock. Three modes are supported: free-run at a programmable rate, single-step from a button, and halt, with a PC breakpoint. It also snapshots PC/WriteData for the 7-segment display and counts retired instructions. It sits between board buttons/Clk and the datapath/display, replacing the free-running divided clock.

---
 rtl/dp_run_ctrl_pkg.sv | 32 +++
 rtl/dp_run_ctrl_btn_debounce.sv | 54 +++++
 rtl/dp_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_dp_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dp_run_ctrl_pkg.sv
// Shared definitions for the datapath execution controller: FSM state encoding
// and the button-event priority resolver.
package dp_run_ctrl_pkg;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    // Encoded so that a larger value means a higher priority.
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_RUN  = 2'd1,
        EV_STEP = 2'd2,
        EV_HALT = 2'd3
    } ev_e;

    function automatic ev_e ev_select(input logic halt_ev, input logic step_ev, input logic run_ev);
        ev_e sel;
        if (halt_ev) begin
            sel = EV_HALT;
        end else if (step_ev) begin
            sel = EV_STEP;
        end else if (run_ev) begin
            sel = EV_RUN;
        end else begin
            sel = EV_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dp_run_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level debounce and a one-cycle
// pulse on each accepted press.
module dp_run_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter tracks how long the synchronized input has disagreed with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/dp_run_ctrl.sv
// Execution controller: issues one-cycle datapath enables in RUN/STEP modes,
// stops on a PC breakpoint, snapshots PC/write data and counts retired instructions.
module dp_run_ctrl
    import dp_run_ctrl_pkg::*;
#(
    parameter int DIV_COUNT       = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PC_W            = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            RunBtn,
    input  logic            StepBtn,
    input  logic            HaltBtn,
    input  logic            BreakEn,
    input  logic [PC_W-1:0] BreakAddr,
    input  logic [PC_W-1:0] ProgramCounter,
    input  logic [31:0]     WriteData,
    output logic            DpEn,
    output logic [15:0]     DispPC,
    output logic [15:0]     DispWD,
    output logic            Halted,
    output logic [31:0]     InstrCount
);

    localparam int PRE_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_COUNT - 1);

    logic             run_ev_s, step_ev_s, halt_ev_s;
    ev_e              ev_s;
    logic             tick_s, hit_s;
    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             bypass_q, bypass_d;
    logic             dpen_q, dpen_d;
    logic             halted_q, halted_d;
    logic [15:0]      disp_pc_q, disp_pc_d;
    logic [15:0]      disp_wd_q, disp_wd_d;
    logic [31:0]      count_q, count_d;
    logic             unused_wd_s;

    dp_run_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk_i(Clk), .rst_ni(Reset), .btn_i(RunBtn), .rise_o(run_ev_s));
    dp_run_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk_i(Clk), .rst_ni(Reset), .btn_i(StepBtn), .rise_o(step_ev_s));
    dp_run_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
        .clk_i(Clk), .rst_ni(Reset), .btn_i(HaltBtn), .rise_o(halt_ev_s));

    assign unused_wd_s = ^WriteData[31:16];

    // Mode FSM; the prescaler idles at zero outside RUN so every RUN entry starts a full period.
    always_comb begin
        ev_s     = ev_select(halt_ev_s, step_ev_s, run_ev_s);
        tick_s   = (state_q == ST_RUN) && (pre_q == PRE_MAX);
        hit_s    = BreakEn && (ProgramCounter == BreakAddr) && !bypass_q;
        state_d  = state_q;
        pre_d    = '0;
        dpen_d   = 1'b0;
        bypass_d = bypass_q;
        case (state_q)
            ST_HALT: begin
                if (ev_s == EV_STEP) begin
                    state_d = ST_STEP;
                    dpen_d  = 1'b1;
                end else if (ev_s == EV_RUN) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_RUN: begin
                if (ev_s == EV_HALT) begin
                    state_d = ST_HALT;
                end else if (tick_s) begin
                    if (hit_s) begin
                        state_d = ST_BREAK;
                    end else begin
                        dpen_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            ST_BREAK: begin
                if (ev_s == EV_HALT) begin
                    state_d = ST_HALT;
                end else if (ev_s == EV_STEP) begin
                    state_d = ST_STEP;
                    dpen_d  = 1'b1;
                end else if (ev_s == EV_RUN) begin
                    state_d  = ST_RUN;
                    bypass_d = 1'b1;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        // Any issued instruction consumes the breakpoint bypass.
        if (dpen_d) begin
            bypass_d = 1'b0;
        end else begin
            bypass_d = bypass_d;
        end
        halted_d = (state_d == ST_HALT) || (state_d == ST_BREAK);
    end

    always_comb begin
        if (dpen_q) begin
            count_d   = count_q + 32'd1;
            disp_pc_d = ProgramCounter[15:0];
            disp_wd_d = WriteData[15:0];
        end else begin
            count_d   = count_q;
            disp_pc_d = disp_pc_q;
            disp_wd_d = disp_wd_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_HALT;
            pre_q     <= '0;
            bypass_q  <= 1'b0;
            dpen_q    <= 1'b0;
            halted_q  <= 1'b1;
            disp_pc_q <= 16'h0000;
            disp_wd_q <= 16'h0000;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            bypass_q  <= bypass_d;
            dpen_q    <= dpen_d;
            halted_q  <= halted_d;
            disp_pc_q <= disp_pc_d;
            disp_wd_q <= disp_wd_d;
            count_q   <= count_d;
        end
    end

    assign DpEn       = dpen_q;
    assign DispPC     = disp_pc_q;
    assign DispWD     = disp_wd_q;
    assign Halted     = halted_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_dp_run_ctrl.sv
// Directed bench for dp_run_ctrl with DIV_COUNT=4, DEBOUNCE_CYCLES=3: a vector table
// of button sequences from HALT plus hand-written run, breakpoint, reset and wrap cases.
module tb_dp_run_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        RunBtn = 1'b0, StepBtn = 1'b0, HaltBtn = 1'b0, BreakEn = 1'b0;
    logic [31:0] BreakAddr = 32'd0;
    logic [31:0] WriteData = 32'hABCD_1234;
    logic [31:0] pc_q = 32'd0;
    logic [31:0] pc_ld_val = 32'd0;
    logic        pc_ld = 1'b0;
    logic        DpEn, Halted;
    logic [15:0] DispPC, DispWD;
    logic [31:0] InstrCount;

    int   checks = 0, failures = 0, pulses = 0, viol = 0, waited = 0;
    logic prev_en = 1'b0;

    typedef struct {
        string       name;
        logic        run, step, halt;
        int          hold, idle, exp_pulses;
        logic        exp_halted;
        logic [31:0] exp_count;
        logic [15:0] exp_pc, exp_wd;
    } vec_t;
    vec_t tbl [6];

    dp_run_ctrl #(.DIV_COUNT(4), .DEBOUNCE_CYCLES(3), .PC_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .RunBtn(RunBtn), .StepBtn(StepBtn), .HaltBtn(HaltBtn),
        .BreakEn(BreakEn), .BreakAddr(BreakAddr), .ProgramCounter(pc_q), .WriteData(WriteData),
        .DpEn(DpEn), .DispPC(DispPC), .DispWD(DispWD), .Halted(Halted), .InstrCount(InstrCount));

    always #5 Clk = ~Clk;

    // Datapath PC model: advances by one instruction on every enabled clock.
    always @(posedge Clk) begin
        if (pc_ld) pc_q <= pc_ld_val;
        else if (DpEn) pc_q <= pc_q + 32'd4;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            if (DpEn === 1'b1) begin
                pulses++;
                if (prev_en) viol++;
            end
            prev_en = DpEn;
        end
    endtask

    task automatic wait_pulse(input string nm, input int max);
        waited = 0;
        do begin
            cyc(1);
            waited++;
        end while (DpEn !== 1'b1 && waited < max);
        chk(nm, {31'd0, DpEn}, 32'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b0; RunBtn = 1'b0; StepBtn = 1'b0; HaltBtn = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        prev_en = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_ld_val = v; pc_ld = 1'b1;
        cyc(1);
        pc_ld = 1'b0;
    endtask

    task automatic set_vec(input int i, input string nm, input logic r, input logic s, input logic h,
                           input int hold, input int idle, input int ep, input logic eh,
                           input logic [31:0] ec, input logic [15:0] epc, input logic [15:0] ewd);
        tbl[i].name = nm; tbl[i].run = r; tbl[i].step = s; tbl[i].halt = h;
        tbl[i].hold = hold; tbl[i].idle = idle; tbl[i].exp_pulses = ep;
        tbl[i].exp_halted = eh; tbl[i].exp_count = ec; tbl[i].exp_pc = epc; tbl[i].exp_wd = ewd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // name, run, step, halt, hold, idle, pulses, halted, count, DispPC, DispWD
        set_vec(0, "idle",      1'b0, 1'b0, 1'b0,  0, 100, 0, 1'b1, 32'd0, 16'h0000, 16'h0000);
        set_vec(1, "step",      1'b0, 1'b1, 1'b0, 20,  10, 1, 1'b1, 32'd1, 16'h0010, 16'h1234);
        set_vec(2, "glitch",    1'b0, 1'b1, 1'b0,  2,  10, 0, 1'b1, 32'd1, 16'h0010, 16'h1234);
        set_vec(3, "halt_idle", 1'b0, 1'b0, 1'b1, 10,  10, 0, 1'b1, 32'd1, 16'h0010, 16'h1234);
        set_vec(4, "halt_run",  1'b1, 1'b0, 1'b1, 10,  10, 0, 1'b1, 32'd1, 16'h0010, 16'h1234);
        set_vec(5, "step_run",  1'b1, 1'b1, 1'b0, 10,  10, 1, 1'b1, 32'd2, 16'h0014, 16'h1234);

        do_reset();
        Reset = 1'b0;
        #1;
        chk("rst_dpen", {31'd0, DpEn}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd1);
        chk("rst_count", InstrCount, 32'd0);
        chk("rst_disppc", {16'd0, DispPC}, 32'd0);
        do_reset();
        load_pc(32'h10);

        for (int i = 0; i < 6; i++) begin
            pulses = 0;
            RunBtn = tbl[i].run; StepBtn = tbl[i].step; HaltBtn = tbl[i].halt;
            cyc(tbl[i].hold);
            RunBtn = 1'b0; StepBtn = 1'b0; HaltBtn = 1'b0;
            cyc(tbl[i].idle);
            chk({tbl[i].name, "_pulses"}, 32'(pulses), 32'(tbl[i].exp_pulses));
            chk({tbl[i].name, "_halted"}, {31'd0, Halted}, {31'd0, tbl[i].exp_halted});
            chk({tbl[i].name, "_count"}, InstrCount, tbl[i].exp_count);
            chk({tbl[i].name, "_disppc"}, {16'd0, DispPC}, {16'd0, tbl[i].exp_pc});
            chk({tbl[i].name, "_dispwd"}, {16'd0, DispWD}, {16'd0, tbl[i].exp_wd});
        end

        // Free run: pulses every 4 cycles; a halt that lands on a tick suppresses that pulse.
        do_reset();
        RunBtn = 1'b1;
        wait_pulse("run_first", 40);
        RunBtn = 1'b0;
        chk("run_halted", {31'd0, Halted}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            wait_pulse("run_next", 10);
            chk("run_period", 32'(waited), 32'd4);
        end
        cyc(2);
        HaltBtn = 1'b1;
        pulses = 0;
        cyc(30);
        HaltBtn = 1'b0;
        chk("halt_pulses", 32'(pulses), 32'd1);
        chk("halt_halted", {31'd0, Halted}, 32'd1);
        chk("halt_count", InstrCount, 32'd5);

        // Breakpoint at 0x0C, then resume executes the breakpoint instruction.
        do_reset();
        load_pc(32'h0);
        BreakEn = 1'b1; BreakAddr = 32'h0C;
        pulses = 0;
        RunBtn = 1'b1;
        cyc(10);
        RunBtn = 1'b0;
        cyc(40);
        chk("brk_pulses", 32'(pulses), 32'd3);
        chk("brk_halted", {31'd0, Halted}, 32'd1);
        chk("brk_pc", pc_q, 32'h0C);
        chk("brk_disppc", {16'd0, DispPC}, 32'h8);
        RunBtn = 1'b1;
        wait_pulse("resume_first", 40);
        RunBtn = 1'b0;
        cyc(1);
        chk("resume_disppc", {16'd0, DispPC}, 32'h0C);
        wait_pulse("resume_next", 10);
        cyc(1);
        chk("resume_disppc2", {16'd0, DispPC}, 32'h10);
        chk("resume_halted", {31'd0, Halted}, 32'd0);
        chk("resume_count", InstrCount, 32'd5);
        BreakEn = 1'b0;

        // Reset landing on a pulse drops DpEn immediately.
        do_reset();
        RunBtn = 1'b1;
        wait_pulse("rr_first", 40);
        wait_pulse("rr_second", 10);
        Reset = 1'b0; RunBtn = 1'b0;
        #1;
        chk("rr_dpen", {31'd0, DpEn}, 32'd0);
        chk("rr_halted", {31'd0, Halted}, 32'd1);
        chk("rr_count", InstrCount, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        prev_en = 1'b0;
        pulses = 0;
        cyc(20);
        chk("rr_after_pulses", 32'(pulses), 32'd0);

        // Counter wrap.
        do_reset();
        force dut.count_d = 32'hFFFF_FFFF;
        cyc(1);
        release dut.count_d;
        cyc(1);
        chk("wrap_preload", InstrCount, 32'hFFFF_FFFF);
        pulses = 0;
        StepBtn = 1'b1;
        cyc(10);
        StepBtn = 1'b0;
        cyc(10);
        chk("wrap_pulses", 32'(pulses), 32'd1);
        chk("wrap_count", InstrCount, 32'd0);

        chk("no_back_to_back", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
